memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory stage of the RISC-V pipeline core, directly upstream of the writeback stage. It takes M-stage operands from the E/M register and issues loads and stores on a registered data-memory bus that is stretched by `o_p_waitrequest`. It formats load data and store byte lanes, and stalls the front of the pipeline while an access is outstanding. It owns the M/W pipeline register that feeds `ResultSrcW`, `PCPlus4W`, `ALU_ResultW` and `ReadDataW` to writeback.

## Interface
No parameters; data width fixed at 32.
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `RegWriteM`  in  1  M-stage instruction writes rd
- `ResultSrcM`  in  1  1 = load (result from memory)
- `MemWriteM`  in  1  1 = store
- `funct3M`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- `RdM`  in  5  destination register
- `PCPlus4M`  in  32  PC+4 of M instruction
- `ALU_ResultM`  in  32  effective address / ALU result
- `WriteDataM`  in  32  store data (rs2)
- `p_address`  out  32  word-aligned bus address
- `p_read` / `p_write`  out  1  bus read / write request
- `p_writedata`  out  32  lane-replicated store data
- `p_byteenable`  out  4  active byte lanes
- `p_readdata`  in  32  read data, valid when `o_p_waitrequest`=0 during read
- `o_p_waitrequest`  in  1  slave busy; request must be held
- `StallM`  out  1  freeze F/D/E/M registers this cycle
- `RegWriteW`, `ResultSrcW`, `RdW`, `PCPlus4W`, `ALU_ResultW`, `ReadDataW`, `MisalignW`  out  M/W register to writeback

## Operation
- Memory op = `ResultSrcM | MemWriteM`. Offset = `ALU_ResultM[1:0]`.
- Misaligned = h/hu at odd offset, w at offset ≠0, or `funct3M` not listed above. A misaligned op issues no bus cycle and does not stall. It passes to W with `RegWriteW`=0 and `MisalignW`=1 (one cycle).
- FSM states IDLE, REQ.
  - IDLE, non-memory op or misaligned: `StallM`=0; M/W loads M values in one cycle.
  - IDLE, aligned memory op: `StallM`=1. At the edge, the bus registers capture the request and the state goes to REQ. M/W loads a bubble (all control 0).
  - REQ: `p_read`/`p_write` held high with stable address, data and byte enables.
  - REQ, `o_p_waitrequest`=1: `StallM`=1, bubble into W, stay in REQ.
  - REQ, `o_p_waitrequest`=0: `StallM`=0. At the edge, M/W captures the instruction and the formatted `ReadDataW`, bus request drops, and the state returns to IDLE.
- `p_address` = `{ALU_ResultM[31:2],2'b00}`.
- Store lanes:
  - sb: `p_byteenable` = `4'b0001<<off`, `p_writedata` = `{4{WriteDataM[7:0]}}`.
  - sh: `p_byteenable` = `0011`/`1100`, `p_writedata` = `{2{WriteDataM[15:0]}}`.
  - sw: `p_byteenable` = `1111`.
- Loads use `p_byteenable` = `1111`. The byte/halfword is selected by offset, then sign-extended (b, h) or zero-extended (bu, hu).
- Stores leave `ReadDataW` at 0.
- `ALU_ResultW` always carries `ALU_ResultM`.
- During reset all outputs = 0 and state = IDLE.

## Timing
- Non-memory op: 1 cycle in M.
- Aligned load/store: 2 + N cycles in M, where N = cycles with `o_p_waitrequest`=1 in REQ. N=0 gives exactly one stall cycle.
- Bus outputs are registered and change only on issue or completion edges. `StallM` is combinational from state, M inputs and `o_p_waitrequest`.
- `o_p_waitrequest` is ignored in IDLE.
- Back-to-back memory ops: every op re-enters IDLE for one cycle, so the bus is idle for at least one cycle between requests.
- Async `rst` low mid-access: the bus request drops immediately, with no completion into W. After release the M op is re-issued from IDLE.
- Upstream must keep M inputs stable while `StallM`=1.

## Test plan
- After `rst` release with an add in M (`ALU_ResultM`=0x1234, `RegWriteM`=1): `StallM`=0, and the next cycle `ALU_ResultW`=0x1234, `RegWriteW`=1.
- lw at 0x100, waitrequest low: one cycle with `StallM`=1, then `p_read`=1, `p_address`=0x100. With `p_readdata`=0xDEADBEEF, `ReadDataW`=0xDEADBEEF, `ResultSrcW`=1 the following cycle.
- lb at 0x103 with `p_readdata`=0x80FF0000 gives `ReadDataW`=0xFFFFFF80. lbu at the same address gives 0x00000080. lhu at 0x102 gives 0x000080FF.
- sb at 0x101 with `WriteDataM`=0xAB, and `o_p_waitrequest` high for 3 cycles: `p_byteenable`=0010, `p_writedata`=0xABABABAB held for 4 cycles, `StallM` high 4 cycles total, `RegWriteW`=0 throughout.
- lw at 0x102: no `p_read`, `StallM`=0, `MisalignW`=1, `RegWriteW`=0 for one cycle.
- `rst` asserted in REQ with waitrequest high: `p_read`=0 and all W outputs 0 immediately. After release, the same lw issues again from IDLE.

Source files
------------

// File: rtl/memory_cycle.sv
// Memory stage: issues registered loads/stores on a waitrequest-stretched bus,
// formats load data and store lanes, and owns the M/W pipeline register.
module memory_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] p_address,
   output logic        p_read,
   output logic        p_write,
   output logic [31:0] p_writedata,
   output logic [3:0]  p_byteenable,
   input  logic [31:0] p_readdata,
   input  logic        o_p_waitrequest,
   output logic        StallM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RdW,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MisalignW
);

   typedef enum logic {StIdle, StReq} state_e;

   state_e      state_q, state_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        reg_write_q, reg_write_d;
   logic        result_src_q, result_src_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] read_data_q, read_data_d;
   logic        misalign_q, misalign_d;

   logic        mem_op;
   logic        bad_align;
   logic        misalign;
   logic        stall;
   logic [1:0]  off;
   logic [31:0] lane;
   logic [31:0] load_data;
   logic [31:0] st_data;
   logic [3:0]  st_be;

   assign mem_op   = ResultSrcM | MemWriteM;
   assign off      = ALU_ResultM[1:0];
   assign misalign = mem_op & bad_align;

   always_comb begin
      bad_align = 1'b1;
      case (funct3M)
         3'b000, 3'b100: bad_align = 1'b0;
         3'b001, 3'b101: bad_align = off[0];
         3'b010:         bad_align = (off != 2'b00);
         default:        bad_align = 1'b1;
      endcase
   end

   // Lane select uses the M offset, which upstream holds stable while stalled.
   assign lane = p_readdata >> {off, 3'b000};

   always_comb begin
      load_data = p_readdata;
      case (funct3M)
         3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_data = {24'h0, lane[7:0]};
         3'b101:  load_data = {16'h0, lane[15:0]};
         default: load_data = p_readdata;
      endcase
   end

   always_comb begin
      st_data = WriteDataM;
      st_be   = 4'b1111;
      case (funct3M[1:0])
         2'b00: begin
            st_data = {4{WriteDataM[7:0]}};
            st_be   = 4'b0001 << off;
         end
         2'b01: begin
            st_data = {2{WriteDataM[15:0]}};
            st_be   = off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = WriteDataM;
            st_be   = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      stall        = 1'b0;
      read_d       = read_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      // Default M/W load is a bubble; the ALU result always passes through.
      reg_write_d  = 1'b0;
      result_src_d = 1'b0;
      rd_d         = 5'd0;
      pc_plus4_d   = 32'h0;
      alu_result_d = ALU_ResultM;
      read_data_d  = 32'h0;
      misalign_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (mem_op && !misalign) begin
               stall   = 1'b1;
               state_d = StReq;
               read_d  = ResultSrcM;
               write_d = MemWriteM & ~ResultSrcM;
               addr_d  = {ALU_ResultM[31:2], 2'b00};
               wdata_d = ResultSrcM ? 32'h0 : st_data;
               be_d    = ResultSrcM ? 4'b1111 : st_be;
            end else begin
               reg_write_d  = RegWriteM & ~misalign;
               result_src_d = ResultSrcM;
               rd_d         = RdM;
               pc_plus4_d   = PCPlus4M;
               misalign_d   = misalign;
            end
         end
         StReq: begin
            if (o_p_waitrequest) begin
               stall = 1'b1;
            end else begin
               state_d      = StIdle;
               read_d       = 1'b0;
               write_d      = 1'b0;
               addr_d       = 32'h0;
               wdata_d      = 32'h0;
               be_d         = 4'h0;
               reg_write_d  = RegWriteM;
               result_src_d = ResultSrcM;
               rd_d         = RdM;
               pc_plus4_d   = PCPlus4M;
               read_data_d  = read_q ? load_data : 32'h0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         be_q         <= 4'h0;
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= 5'd0;
         pc_plus4_q   <= 32'h0;
         alu_result_q <= 32'h0;
         read_data_q  <= 32'h0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         read_q       <= read_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         pc_plus4_q   <= pc_plus4_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         misalign_q   <= misalign_d;
      end
   end

   // Stall is forced low while reset is held so every output reads 0.
   assign StallM       = rst & stall;
   assign p_read       = read_q;
   assign p_write      = write_q;
   assign p_address    = addr_q;
   assign p_writedata  = wdata_q;
   assign p_byteenable = be_q;
   assign RegWriteW    = reg_write_q;
   assign ResultSrcW   = result_src_q;
   assign RdW          = rd_q;
   assign PCPlus4W     = pc_plus4_q;
   assign ALU_ResultW  = alu_result_q;
   assign ReadDataW    = read_data_q;
   assign MisalignW    = misalign_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed cases plus randomized ops
// checked against an arithmetic model of the access rules.
module tb_memory_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, ResultSrcM, MemWriteM;
   logic [2:0]  funct3M;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
   logic [31:0] p_address, p_writedata, p_readdata;
   logic        p_read, p_write, o_p_waitrequest, StallM;
   logic [3:0]  p_byteenable;
   logic        RegWriteW, ResultSrcW, MisalignW;
   logic [4:0]  RdW;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

   int n_checks = 0;
   int n_errors = 0;

   memory_cycle dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .funct3M(funct3M), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
      .p_address(p_address), .p_read(p_read), .p_write(p_write),
      .p_writedata(p_writedata), .p_byteenable(p_byteenable),
      .p_readdata(p_readdata), .o_p_waitrequest(o_p_waitrequest),
      .StallM(StallM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
      .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
      .MisalignW(MisalignW)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      return (addr % 4) % acc_size(f3) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      longint unsigned shifted = longint'(rdata) >> (8 * (addr % 4));
      longint m = longint'(1) << (8 * acc_size(f3));
      longint v = longint'(shifted % m);
      if (!f3[2] && acc_size(f3) < 4 && v >= m / 2) v = v - m;
      return 32'(v);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int mask = ((1 << acc_size(f3)) - 1) << (addr % 4);
      return 4'(mask);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (acc_size(f3))
         1:       return (wd % 256) * 32'h01010101;
         2:       return (wd % 65536) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   // Call just after a rising edge; returns just after the op's final edge in M.
   task automatic run_op(input logic rw, input logic rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rdata, input string tag);
      logic [4:0]  rd = 5'($urandom);
      logic [31:0] pc = $urandom;
      bit mem = rs | mw;
      bit mis = mem && model_misaligned(f3, addr);
      bit issue = mem && !mis;
      int stalls = 0;
      RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3; RdM = rd;
      PCPlus4M = pc; ALU_ResultM = addr; WriteDataM = wd;
      o_p_waitrequest = 1'($urandom);
      p_readdata = $urandom;
      @(negedge clk);
      check({tag, ".stall_idle"}, 32'(StallM), 32'(issue));
      if (StallM) stalls++;
      @(posedge clk); #1;
      if (!issue) begin
         check({tag, ".p_read"}, 32'(p_read), 32'h0);
         check({tag, ".p_write"}, 32'(p_write), 32'h0);
         check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(rw && !mis));
         check({tag, ".MisalignW"}, 32'(MisalignW), 32'(mis));
         check({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(rs));
         check({tag, ".RdW"}, 32'(RdW), 32'(rd));
         check({tag, ".PCPlus4W"}, PCPlus4W, pc);
         check({tag, ".ALU_ResultW"}, ALU_ResultW, addr);
         check({tag, ".ReadDataW"}, ReadDataW, 32'h0);
         return;
      end
      for (int k = 0; k <= nwait; k++) begin
         check({tag, ".p_read"}, 32'(p_read), 32'(rs));
         check({tag, ".p_write"}, 32'(p_write), 32'(mw && !rs));
         check({tag, ".p_address"}, p_address, addr & 32'hFFFF_FFFC);
         check({tag, ".p_byteenable"}, 32'(p_byteenable), rs ? 32'hF : 32'(model_be(f3, addr)));
         if (!rs) check({tag, ".p_writedata"}, p_writedata, model_wdata(f3, wd));
         check({tag, ".bubble_RegWriteW"}, 32'(RegWriteW), 32'h0);
         check({tag, ".bubble_ResultSrcW"}, 32'(ResultSrcW), 32'h0);
         check({tag, ".bubble_MisalignW"}, 32'(MisalignW), 32'h0);
         o_p_waitrequest = (k < nwait);
         p_readdata = (k < nwait) ? $urandom : rdata;
         @(negedge clk);
         check({tag, ".stall_req"}, 32'(StallM), 32'(k < nwait));
         if (StallM) stalls++;
         @(posedge clk); #1;
      end
      o_p_waitrequest = 1'b0;
      check({tag, ".stall_total"}, 32'(stalls), 32'(1 + nwait));
      check({tag, ".done_p_read"}, 32'(p_read), 32'h0);
      check({tag, ".done_p_write"}, 32'(p_write), 32'h0);
      check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(rw));
      check({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(rs));
      check({tag, ".MisalignW"}, 32'(MisalignW), 32'h0);
      check({tag, ".RdW"}, 32'(RdW), 32'(rd));
      check({tag, ".PCPlus4W"}, PCPlus4W, pc);
      check({tag, ".ALU_ResultW"}, ALU_ResultW, addr);
      check({tag, ".ReadDataW"}, ReadDataW, rs ? model_load(f3, addr, rdata) : 32'h0);
   endtask

   initial begin
      logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst = 1'b0;
      {RegWriteM, ResultSrcM, MemWriteM} = 3'b000;
      funct3M = 3'd0; RdM = 5'd0; PCPlus4M = 32'h0; ALU_ResultM = 32'h0; WriteDataM = 32'h0;
      p_readdata = 32'h0; o_p_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.p_read", 32'(p_read), 32'h0);
      check("rst.StallM", 32'(StallM), 32'h0);
      check("rst.RegWriteW", 32'(RegWriteW), 32'h0);
      check("rst.ALU_ResultW", ALU_ResultW, 32'h0);
      check("rst.p_address", p_address, 32'h0);
      rst = 1'b1;

      run_op(1, 0, 0, 3'd0, 32'h1234, 32'h0, 0, 32'h0, "add");
      run_op(1, 1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, "lw");
      run_op(1, 1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF0000, "lb");
      run_op(1, 1, 0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF0000, "lbu");
      run_op(1, 1, 0, 3'd5, 32'h102, 32'h0, 2, 32'h80FF0000, "lhu");
      run_op(0, 0, 1, 3'd0, 32'h101, 32'hAB, 3, 32'h0, "sb");
      run_op(0, 0, 1, 3'd1, 32'h102, 32'h1234CDEF, 0, 32'h0, "sh");
      run_op(1, 1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0, "lw_mis");

      // Reset in the middle of a stretched read.
      RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0; funct3M = 3'd2;
      ALU_ResultM = 32'h200; o_p_waitrequest = 1'b1;
      @(posedge clk); #1;
      check("rstmid.p_read_before", 32'(p_read), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid.p_read", 32'(p_read), 32'h0);
      check("rstmid.StallM", 32'(StallM), 32'h0);
      check("rstmid.RegWriteW", 32'(RegWriteW), 32'h0);
      check("rstmid.ALU_ResultW", ALU_ResultW, 32'h0);
      check("rstmid.p_address", p_address, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_op(1, 1, 0, 3'd2, 32'h200, 32'h0, 1, 32'h01234567, "lw_reissue");

      for (int i = 0; i < 300; i++) begin
         int kind = $urandom_range(0, 2);
         logic [2:0] f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom)
                                                       : legal_f3[$urandom_range(0, 4)];
         run_op(1'($urandom), kind == 1, kind == 2, f3, $urandom, $urandom,
                $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
